// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: data width, FSM encoding,
// queue entry layout and the fetch address range helper.
package inst_fetch_unit_pkg;

    localparam int DW = 32;
    localparam logic [DW-1:0] ZERO = 32'h0000_0000;
    localparam logic [DW-1:0] NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_RUN  = 2'b01,
        IF_HALT = 2'b10
    } if_state_e;

    typedef struct packed {
        logic [31:0]   pc;
        logic [DW-1:0] inst;
    } fetch_entry_t;

    // True when the byte PC points beyond an imem of 2**aw words.
    function automatic logic pc_out_of_range(input logic [31:0] pc, input int aw);
        logic [31:0] hi;
        hi = pc >> (aw + 2);
        return (hi != 32'd0);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Two-entry FIFO of {pc, inst} between imem responses and decode.
// Flush has priority over a simultaneous push; pop is only requested when non-empty.
module inst_fetch_unit_fetch_queue
    import inst_fetch_unit_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t [1:0] mem_q, mem_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_entry_i;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, request FSM and a one-deep in-flight tracker feeding a 2-entry queue.
// Optional FETCH_BOUND_CHECK_EN halts on fetches outside the imem range and flags Fetch_err_o.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int          AW       = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [AW-1:0] Imem_addr_o,
    output logic          Imem_read_en_o,
    input  logic [DW-1:0] Imem_data_i,
    input  logic          Branch_valid_i,
    input  logic [31:0]   Branch_target_i,
    input  logic          Dec_ready_i,
    output logic          Inst_valid_o,
    output logic [DW-1:0] Inst_o,
    output logic [31:0]   Inst_pc_o,
    output logic          Fetch_err_o
);

    if_state_e     state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          read_en_q, read_en_d;
    logic          pending_q, pending_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          err_q, err_d;

    logic [31:0]   fetch_pc_s;
    logic          want_s;
    logic          bound_err_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic [1:0]    count_s;
    logic [2:0]    occupancy_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_s;

    assign pop_s        = Inst_valid_o && Dec_ready_i;
    // A branch discards whatever response lands on its edge.
    assign push_s       = pending_q && !Branch_valid_i;
    assign flush_s      = Branch_valid_i;
    assign push_entry_s = '{pc: req_pc_q, inst: Imem_data_i};
    assign occupancy_s  = {1'b0, count_s} + {2'b00, pending_q};

    // Request generation, branch redirect and FSM next state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        read_en_d   = 1'b0;
        pending_d   = 1'b0;
        req_pc_d    = req_pc_q;
        err_d       = err_q;
        fetch_pc_s  = pc_q;
        want_s      = 1'b0;
        bound_err_s = 1'b0;
        case (state_q)
            IF_IDLE: begin
                state_d = IF_RUN;
            end
            IF_RUN: begin
                if (Branch_valid_i) begin
                    fetch_pc_s = Branch_target_i & ~32'h0000_0003;
                    want_s     = 1'b1;
                end else begin
                    fetch_pc_s = pc_q;
                    want_s     = (occupancy_s < 3'(QDEPTH)) || pop_s;
                end
`ifdef FETCH_BOUND_CHECK_EN
                bound_err_s = want_s && pc_out_of_range(fetch_pc_s, AW);
`else
                bound_err_s = 1'b0;
`endif
                if (bound_err_s) begin
                    err_d   = 1'b1;
                    state_d = IF_HALT;
                end else if (want_s) begin
                    read_en_d = 1'b1;
                    addr_d    = fetch_pc_s[AW+1:2];
                    pc_d      = fetch_pc_s + 32'd4;
                    req_pc_d  = fetch_pc_s;
                    pending_d = 1'b1;
                end else begin
                    read_en_d = 1'b0;
                end
            end
            IF_HALT: begin
                state_d = IF_HALT;
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    // Fetch control registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IF_IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC[AW+1:2];
            read_en_q <= 1'b0;
            pending_q <= 1'b0;
            req_pc_q  <= 32'h0000_0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            read_en_q <= read_en_d;
            pending_q <= pending_d;
            req_pc_q  <= req_pc_d;
            err_q     <= err_d;
        end
    end

    inst_fetch_unit_fetch_queue u_fetch_queue (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push_s),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .flush_i      (flush_s),
        .head_o       (head_s),
        .count_o      (count_s)
    );

    assign Imem_addr_o    = addr_q;
    assign Imem_read_en_o = read_en_q;
    assign Inst_valid_o   = (count_s != 2'd0);
    assign Inst_o         = head_s.inst;
    assign Inst_pc_o      = head_s.pc;
    assign Fetch_err_o    = err_q;

endmodule
